// File: rtl/relu_pkg.sv
// Shared constants for the ReLU stream controller: default widths and FSM encoding.
package relu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_LEN_W  = 16;
    localparam int unsigned SIGN_BIT   = DEF_DATA_W - 1;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/relu_core.sv
// Combinational ReLU core: negative words clamp to zero, others pass unchanged.
module relu_core
    import relu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned SIGN_IDX = SIGN_BIT
) (
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid_c,
    output logic [DATA_W-1:0] out_data_c,
    output logic              out_neg_c
);

    assign out_valid_c = in_valid;
    assign out_neg_c   = in_valid && in_data[SIGN_IDX];
    assign out_data_c  = in_data[SIGN_IDX] ? '0 : in_data;

endmodule

// File: rtl/relu_res_fifo.sv
// Two-entry result buffer; entry 0 is always the head so the write data comes straight from a flop.
module relu_res_fifo
    import relu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
    assign head    = d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            d0  <= '0;
            d1  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == '0) d0 <= din;
                    else           d1 <= din;
                    cnt <= cnt + CNT_W'(1);
                end
                2'b01: begin
                    d0  <= d1;
                    cnt <= cnt - CNT_W'(1);
                end
                2'b11: begin
                    // Head leaves while a new word arrives; the count is unchanged.
                    if (cnt == CNT_W'(1)) begin
                        d0 <= din;
                    end else begin
                        d0 <= d1;
                        d1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Streams Len words from a source buffer through ReLU into a destination buffer,
// with credit-based read issue so the two-entry result buffer never overflows.
module relu_stream_ctrl
    import relu_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] Src_Base,
    input  logic [ADDR_W-1:0] Dst_Base,
    input  logic [LEN_W-1:0]  Len,
    output logic              Rd_En,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [DATA_W-1:0] Wr_Data,
    input  logic              Wr_Ready,
    output logic              Busy,
    output logic              Done,
    output logic [LEN_W-1:0]  Neg_Count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W-1:0] fifo_head;
    logic [OCC_W-1:0]  occ;

    logic              relu_valid_c;
    logic [DATA_W-1:0] relu_data_c;
    logic              relu_neg_c;

    logic rd_en_c;
    logic wr_en_c;
    logic pop_c;
    logic push_c;
    logic fifo_clr_c;
    logic start_run_c;
    logic start_empty_c;
    logic last_wr_c;

    relu_core #(
        .DATA_W   (DATA_W),
        .SIGN_IDX (DATA_W - 1)
    ) u_core (
        .in_valid    (inflight),
        .in_data     (Rd_Data),
        .out_valid_c (relu_valid_c),
        .out_data_c  (relu_data_c),
        .out_neg_c   (relu_neg_c)
    );

    relu_res_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (relu_data_c),
        .head  (fifo_head),
        .cnt   (fifo_cnt)
    );

    // Buffered plus in-flight results; a read may issue only if its result has a slot.
    assign occ = OCC_W'(fifo_cnt) + OCC_W'(inflight);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        rd_en_c       = 1'b0;
        wr_en_c       = 1'b0;
        pop_c         = 1'b0;
        push_c        = 1'b0;
        fifo_clr_c    = 1'b0;
        start_run_c   = 1'b0;
        start_empty_c = 1'b0;
        last_wr_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    if (Len != '0) begin
                        start_run_c = 1'b1;
                        state_next  = ST_RUN;
                    end else begin
                        start_empty_c = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    fifo_clr_c = 1'b1;
                    state_next = ST_FLUSH;
                end else begin
                    wr_en_c   = (fifo_cnt != '0);
                    pop_c     = wr_en_c && Wr_Ready;
                    push_c    = relu_valid_c;
                    rd_en_c   = (rd_cnt < len_q) &&
                                (occ < OCC_W'(FIFO_DEPTH) + OCC_W'(pop_c));
                    last_wr_c = pop_c && (wr_cnt == len_q - LEN_W'(1));
                    if (last_wr_c) state_next = ST_IDLE;
                end
            end
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign Rd_En   = rd_en_c;
    assign Wr_En   = wr_en_c;
    assign Wr_Data = fifo_head;

    // Run counters, addresses, status flags and the clamp counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            inflight  <= 1'b0;
            Rd_Addr   <= '0;
            Wr_Addr   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Neg_Count <= '0;
        end else begin
            inflight <= rd_en_c;
            Busy     <= (state_next != ST_IDLE);
            Done     <= start_empty_c || last_wr_c;
            if (start_run_c) begin
                len_q     <= Len;
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                Rd_Addr   <= Src_Base;
                Wr_Addr   <= Dst_Base;
                Neg_Count <= '0;
            end else begin
                if (rd_en_c) begin
                    rd_cnt  <= rd_cnt + LEN_W'(1);
                    Rd_Addr <= Rd_Addr + ADDR_W'(1);
                end
                if (pop_c) begin
                    wr_cnt  <= wr_cnt + LEN_W'(1);
                    Wr_Addr <= Wr_Addr + ADDR_W'(1);
                end
                if (push_c && relu_neg_c && (Neg_Count != '1)) begin
                    Neg_Count <= Neg_Count + LEN_W'(1);
                end
                if (start_empty_c) Neg_Count <= '0;
            end
        end
    end

endmodule

// File: doc/relu_stream_ctrl.md
Name: relu_stream_ctrl

Overview:
- Sequences the combinational ReLU datapath over a feature-map region in memory.
- On Start, it streams Len words from a source buffer through ReLU and writes the results to a destination buffer.
- Handles write-port backpressure and counts clamped (negative) elements.
- Sits between the layer scheduler (Start/Done) and the feature-map SRAM ports.

Parameters:
DATA_W, 32, word width; bit DATA_W-1 is the sign bit
ADDR_W, 16, address width for both source and destination
LEN_W, 16, width of the element-count field
FIFO_DEPTH, 2, result buffer depth; fixed at 2, other values unsupported

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle request; sampled only in IDLE
Abort  input  1  cancels the current run
Src_Base  input  ADDR_W  first source address, sampled at Start
Dst_Base  input  ADDR_W  first destination address, sampled at Start
Len  input  LEN_W  element count, sampled at Start
Rd_En  output  1  read request
Rd_Addr  output  ADDR_W  read address
Rd_Data  input  DATA_W  read data, valid exactly 1 cycle after Rd_En
Wr_En  output  1  write request; held until accepted
Wr_Addr  output  ADDR_W  write address
Wr_Data  output  DATA_W  ReLU result
Wr_Ready  input  1  write accepted when Wr_En && Wr_Ready
Busy  output  1  run in progress
Done  output  1  one-cycle completion pulse
Neg_Count  output  LEN_W  number of elements clamped in the current or last run

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Rd_En, Wr_En, Busy and Done go to 0; Rd_Addr, Wr_Addr and Wr_Data go to 0.
  - Neg_Count goes to 0; the FIFO is emptied and the in-flight flag is cleared.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - Start with Len!=0: latch the bases and Len, clear the counters and Neg_Count, go to RUN, Busy=1 from the next cycle.
  - Start with Len==0: Done pulses the next cycle, no memory accesses, Neg_Count is cleared.
- RUN, read issue:
  - Rd_En=1 when rd_cnt<Len and fifo_cnt + inflight - pop < 2, where pop = Wr_En && Wr_Ready.
  - Rd_Addr = Src_Base + rd_cnt, modulo 2^ADDR_W.
  - rd_cnt increments on each issued read.
- RUN, read return:
  - The cycle after Rd_En, Rd_Data is passed through ReLU: sign bit 1 gives 0, otherwise the value passes unchanged.
  - The result is pushed into the FIFO.
  - Neg_Count increments when the sign bit is 1; it saturates at all-ones.
- RUN, write side:
  - Wr_En = FIFO not empty; Wr_Data = FIFO head; Wr_Addr = Dst_Base + wr_cnt, modulo 2^ADDR_W.
  - Wr_Addr and Wr_Data stay stable while Wr_En=1 and Wr_Ready=0.
  - wr_cnt increments on each accepted write.
- Timing:
  - First Rd_En is 1 cycle after Start; first Wr_En is 2 cycles after the first Rd_En.
  - With Wr_Ready held high, throughput is 1 word/cycle.
  - Done pulses 1 cycle after the write handshake with wr_cnt==Len-1, then IDLE; Busy drops in the same cycle Done rises.
- Simultaneous push and pop on the FIFO is legal; the credit rule above guarantees there is never an overflow.
- Abort in RUN:
  - Go to FLUSH: Rd_En and Wr_En are forced to 0 immediately, the FIFO is cleared, and any in-flight read return is discarded.
  - Next cycle go to IDLE with no Done pulse; Neg_Count holds its value.
  - Abort in IDLE is ignored.
- Start while Busy is ignored. Start and Abort together in IDLE: Start wins.
- Reset asserted mid-run: immediate return to reset values; the partial run is not resumed.

Decomposition:
- Shared package relu_pkg holds:
  - state encoding (IDLE/RUN/FLUSH localparams);
  - DATA_W, ADDR_W and LEN_W defaults;
  - a SIGN_BIT constant.
- Instantiate the existing combinational ReLU core on the read-return path, with its valid input driven by the registered in-flight flag.
- One sub-module, relu_res_fifo: a 2-entry synchronous FIFO with push/pop/count and a clear input.

Test Plan:
- Len=4, Src=0x10, Dst=0x80, data {5, 0xFFFFFFFE, 0, 0x7FFFFFFF}, Wr_Ready=1 -> writes 0x80..0x83 = {5, 0, 0, 0x7FFFFFFF} on consecutive cycles; Done 1 cycle after the last write; Neg_Count=1.
- Same run with Wr_Ready low for 3 cycles mid-stream -> Rd_En stalls, at most 2 results buffered, no data lost or duplicated, Wr_Data/Wr_Addr stable while stalled.
- Len=0 -> Done the next cycle, Rd_En/Wr_En never asserted, Neg_Count=0.
- Src_Base=0xFFFE, Len=3 -> Rd_Addr sequence 0xFFFE, 0xFFFF, 0x0000.
- Abort after 2 writes of a Len=8 run -> Rd_En/Wr_En drop the same cycle, no Done, IDLE within 2 cycles; a following Start runs cleanly.
- rst_n pulsed low mid-run and Start pulsed while Busy -> outputs return to reset values asynchronously; the Start during Busy has no effect.
